// File: rtl/program_counter.sv
// Program counter for the multicycle accumulator datapath: picks one of three
// candidate next-PC values and loads it on an unconditional write or taken branch.
module program_counter #(
    parameter int               WIDTH       = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             PCWrite,
    input  logic             Branch,
    input  logic             bneOrbeq,
    input  logic             Zero,
    input  logic [1:0]       PCSrc,
    input  logic [WIDTH-1:0] PCInA,
    input  logic [WIDTH-1:0] PCInB,
    input  logic [WIDTH-1:0] PCInC,
    output logic [WIDTH-1:0] PCOut
);

    logic             take_s;
    logic             load_s;
    logic [WIDTH-1:0] mux_s;
    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] pc_q;

    // Branch decision, load enable and next-PC source selection.
    always_comb begin
        take_s = 1'b0;
        load_s = 1'b0;
        mux_s  = pc_q;
        pc_d   = pc_q;

        // bneOrbeq=1 takes on Zero, bneOrbeq=0 takes on not-Zero
        if (Branch) begin
            take_s = bneOrbeq ? Zero : ~Zero;
        end else begin
            take_s = 1'b0;
        end

        load_s = PCWrite | take_s;

        case (PCSrc)
            2'b00:   mux_s = PCInA;
            2'b01:   mux_s = PCInB;
            2'b10:   mux_s = PCInC;
            default: mux_s = pc_q;   // reserved select keeps the current PC
        endcase

        if (load_s) begin
            pc_d = mux_s;
        end else begin
            pc_d = pc_q;
        end
    end

    // PC state register with asynchronous active-low clear.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            pc_q <= RESET_VALUE;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign PCOut = pc_q;

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: directed scenarios plus randomized
// traffic checked every cycle against a behavioural next-PC model.
module tb_program_counter;

    logic        CLK;
    logic        reset;
    logic        PCWrite;
    logic        Branch;
    logic        bneOrbeq;
    logic        Zero;
    logic [1:0]  PCSrc;
    logic [15:0] PCInA;
    logic [15:0] PCInB;
    logic [15:0] PCInC;
    logic [15:0] PCOut;

    logic [15:0] exp_pc;
    logic        chk_en;
    int          n_chk;
    int          n_err;

    program_counter #(
        .WIDTH      (16),
        .RESET_VALUE(16'h0000)
    ) dut (
        .CLK     (CLK),
        .reset   (reset),
        .PCWrite (PCWrite),
        .Branch  (Branch),
        .bneOrbeq(bneOrbeq),
        .Zero    (Zero),
        .PCSrc   (PCSrc),
        .PCInA   (PCInA),
        .PCInB   (PCInB),
        .PCInC   (PCInC),
        .PCOut   (PCOut)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: PCOut=%h expected=%h at %0t", name, act, req, $time);
        end
    endtask

    // One clock cycle: drive inputs on the falling edge, advance the model at the rising edge.
    task automatic cyc(input logic rst, input logic pw, input logic br, input logic bb,
                       input logic z, input logic [1:0] src,
                       input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
        logic [15:0] cand [4];
        logic [15:0] nxt;
        logic        taken;
        @(negedge CLK);
        reset = rst; PCWrite = pw; Branch = br; bneOrbeq = bb; Zero = z;
        PCSrc = src; PCInA = a; PCInB = b; PCInC = c;
        cand[0] = a; cand[1] = b; cand[2] = c; cand[3] = exp_pc;
        taken = br && (bb == z);
        if (rst == 1'b0) begin
            exp_pc = 16'h0000;
            nxt    = 16'h0000;
        end else if (pw || taken) begin
            nxt = cand[src];
        end else begin
            nxt = exp_pc;
        end
        @(posedge CLK);
        exp_pc = nxt;
    endtask

    // Cycle-by-cycle comparison, sampled well after the rising edge.
    initial begin
        forever begin
            @(posedge CLK);
            #2;
            if (chk_en) check("cycle", PCOut, exp_pc);
        end
    end

    initial begin
        n_chk = 0; n_err = 0; chk_en = 1'b0; exp_pc = 16'h0000;
        reset = 1'b1; PCWrite = 1'b0; Branch = 1'b0; bneOrbeq = 1'b0; Zero = 1'b0;
        PCSrc = 2'b00; PCInA = 16'hFFFF; PCInB = 16'h0000; PCInC = 16'h0000;

        // Asynchronous reset before any clock edge
        #1 reset = 1'b0;
        #1 check("rst_async", PCOut, 16'h0000);
        chk_en = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 16'hFFFF, 16'h0000, 16'h0000);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 16'hFFFF, 16'h0000, 16'h0000);
        #2 check("rst_hold", PCOut, 16'h0000);

        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 16'hFFFF, 16'h0000, 16'h0000);
        #2 check("write_ffff", PCOut, 16'hFFFF);

        cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'b01, 16'h0000, 16'h1111, 16'h0000);
        #2 check("beq_taken", PCOut, 16'h1111);

        cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b01, 16'h0000, 16'h5555, 16'h0000);
        #2 check("beq_not_taken", PCOut, 16'h1111);

        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 16'h0000, 16'h0000, 16'h2222);
        #2 check("bne_taken", PCOut, 16'h2222);

        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 16'h7777, 16'h0000, 16'h0000);
        #2 check("bne_not_taken", PCOut, 16'h2222);

        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'($urandom), 1'($urandom), 2'($urandom),
                16'($urandom), 16'($urandom), 16'($urandom));
            #2 check("hold_idle", PCOut, 16'h2222);
        end

        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b11, 16'hAAAA, 16'hBBBB, 16'hCCCC);
        #2 check("reserved_sel", PCOut, 16'h2222);

        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 16'h3333, 16'h0000, 16'h0000);
        #2 check("write_over_branch", PCOut, 16'h3333);

        // Reset pulled low between clock edges with a write pending
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 16'h0000, 16'h0000, 16'h2222);
        @(negedge CLK);
        PCWrite = 1'b1; PCSrc = 2'b00; PCInA = 16'hFFFF;
        #2 reset = 1'b0;
        exp_pc = 16'h0000;
        #1 check("rst_mid_cycle", PCOut, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 16'hFFFF, 16'h1234, 16'h5678);
            #2 check("rst_mid_hold", PCOut, 16'h0000);
        end
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 16'h0000, 16'h4321, 16'h0000);
        #2 check("after_release", PCOut, 16'h4321);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic [15:0] ra, rb, rc;
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 16'($urandom);
            if ($urandom_range(0, 15) == 0) ra = 16'hFFFF;
            cyc(($urandom_range(0, 31) != 0), ($urandom_range(0, 3) == 0),
                1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), ra, rb, rc);
        end

        chk_en = 1'b0;
        @(negedge CLK);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/program_counter.md
Name:
program_counter

Overview:
- 16-bit program counter register for the multicycle accumulator datapath.
- Selects the next PC from three candidate sources (PCSrc mux), e.g. PC+2 / ALU result, branch target, jump target.
- Loads the selected value on a clock edge when either an unconditional write (PCWrite) or a taken conditional branch (beq/bne) is asserted.
- PCOut feeds instruction memory and the PC-increment/branch-target logic.

Parameters:
- WIDTH, 16, bit width of the PC and all candidate inputs.
- RESET_VALUE, 0, value loaded into the PC while reset is asserted.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; 0 forces PCOut to RESET_VALUE immediately.
- PCWrite  input  1  unconditional PC write enable.
- Branch  input  1  current instruction is a conditional branch.
- bneOrbeq  input  1  branch sense: 1 = beq (take when Zero=1), 0 = bne (take when Zero=0).
- Zero  input  1  ALU zero flag from the branch comparison.
- PCSrc  input  2  next-PC source select.
- PCInA  input  WIDTH  candidate next PC, source 00.
- PCInB  input  WIDTH  candidate next PC, source 01.
- PCInC  input  WIDTH  candidate next PC, source 10.
- PCOut  output  WIDTH  current PC, registered.

Behaviour:
- Reset
  - reset=0 asynchronously clears PCOut to RESET_VALUE, independent of CLK.
  - PCOut holds RESET_VALUE while reset stays low. All other inputs are ignored.
  - Deassertion (0->1) takes effect normally; the first load can occur on the next rising CLK edge.
- Branch condition
  - take = Branch AND (bneOrbeq ? Zero : NOT Zero).
- Load enable
  - load = PCWrite OR take.
- Next-value mux (combinational)
  - PCSrc=00 -> PCInA.
  - PCSrc=01 -> PCInB.
  - PCSrc=10 -> PCInC.
  - PCSrc=11 -> current PCOut (no change). This is a reserved encoding.
- Update
  - On rising CLK with reset=1: if load=1, PCOut <= mux value; otherwise PCOut holds.
  - Latency is one edge; PCOut is purely registered, with no combinational path from inputs to PCOut.
- Simultaneous events
  - PCWrite=1 with Branch=1 loads regardless of Zero/bneOrbeq; PCWrite has priority.
  - Branch=0 ignores Zero and bneOrbeq.
  - reset=0 overrides any load in the same cycle.
- Arithmetic: no arithmetic inside the block; the value is loaded unmodified. The full 16-bit range is passed through, including 16'hFFFF.
- No X propagation: PCOut is always a defined value after the first reset.

Test Plan:
- Reset
  - Stimulus: reset=0 for 2 cycles, PCWrite=0, PCInA=16'hFFFF; then reset=1.
  - Required: PCOut=16'h0000, including mid-cycle, with no clock edge needed.
- Unconditional write
  - Stimulus: after reset, PCWrite=1, PCSrc=00, PCInA=16'hFFFF, one rising edge.
  - Required: PCOut=16'hFFFF.
- beq taken
  - Stimulus: PCWrite=0, PCSrc=01, Branch=1, bneOrbeq=1, Zero=1, PCInB=16'h1111, one edge.
  - Required: PCOut=16'h1111.
- bne / beq not taken
  - Stimulus A: Branch=1, bneOrbeq=1, Zero=0. Required: PCOut holds 16'h1111.
  - Stimulus B: then bneOrbeq=0, Zero=0, PCSrc=10, PCInC=16'h2222, one edge. Required: PCOut=16'h2222.
- Hold and reserved select
  - Stimulus A: PCWrite=0, Branch=0, inputs toggled across several edges. Required: PCOut unchanged.
  - Stimulus B: PCWrite=1, PCSrc=11. Required: PCOut unchanged.
- Async reset mid-operation
  - Stimulus: PCOut=16'h2222, PCWrite=1; pull reset low between clock edges.
  - Required: PCOut=16'h0000 immediately, and it stays 0 through the following edges until reset=1.
